// File: rtl/core_v_mini_mcu_pkg.sv
// Purpose: MCU-level configuration constants.
// Contents: default depth and outstanding limit for the core-port OBI request buffers.
package core_v_mini_mcu_pkg;

  localparam int unsigned ObiBufDepth          = 2;
  localparam int unsigned ObiBufMaxOutstanding = 4;

endpackage

// File: rtl/obi_pkg.sv
// Purpose: OBI request/response payload types shared by the CPU subsystem and bus.
// Contents: obi_req_t (req, addr, we, be, wdata) and obi_resp_t (gnt, rvalid, rdata).
package obi_pkg;

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;
  localparam int unsigned ObiBeW   = ObiDataW / 8;

  typedef struct packed {
    logic                req;
    logic [ObiAddrW-1:0] addr;
    logic                we;
    logic [ObiBeW-1:0]   be;
    logic [ObiDataW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [ObiDataW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_req_buffer_pkg.sv
// Purpose: types and helpers local to the OBI request buffer.
// Contents: obi_buf_entry_t (FIFO payload without the req bit) and to_bus_req(),
//           which rebuilds a bus-side request from a FIFO head entry.
package obi_req_buffer_pkg;

  import obi_pkg::*;

  typedef struct packed {
    logic [ObiAddrW-1:0] addr;
    logic                we;
    logic [ObiBeW-1:0]   be;
    logic [ObiDataW-1:0] wdata;
  } obi_buf_entry_t;

  function automatic obi_req_t to_bus_req(input logic valid, input obi_buf_entry_t e);
    obi_req_t r;
    r       = '0;
    r.req   = valid;
    r.addr  = e.addr;
    r.we    = e.we;
    r.be    = e.be;
    r.wdata = e.wdata;
    return r;
  endfunction

endpackage

// File: rtl/obi_req_buffer_fifo.sv
// Purpose: generic synchronous FIFO used as the request queue of obi_req_buffer.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push, wdata   write strobe and data (ignored when full)
//   pop           advance read pointer (ignored when empty)
//   full, empty   status, derived from the registered occupancy
//   head          entry at the read pointer; all zeros while empty
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module obi_req_buffer_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? T'('0) : mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/obi_req_buffer.sv
// Purpose: OBI request buffer between a core OBI port and the system bus.
//   Core requests are queued and replayed in order on the bus side; core gnt
//   depends only on local state, cutting the bus->core gnt path. Outstanding
//   transactions are counted and capped at MAX_OUTSTANDING.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   core_req_i     request from core
//   core_resp_o    gnt/rvalid/rdata to core
//   bus_req_o      request to bus, taken from FIFO head
//   bus_resp_i     gnt/rvalid/rdata from bus
//   outstanding_o  accepted-but-not-responded count
//   err_o          sticky: bus rvalid seen with nothing outstanding
// Build option: define OBI_REQ_BUFFER_RESP_REG_EN to register rvalid/rdata
//   toward the core (one extra cycle of response latency).
module obi_req_buffer
  import obi_pkg::*;
  import obi_req_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH           = core_v_mini_mcu_pkg::ObiBufDepth,
  parameter  int unsigned MAX_OUTSTANDING = core_v_mini_mcu_pkg::ObiBufMaxOutstanding,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  obi_req_t         core_req_i,
  output obi_resp_t        core_resp_o,
  output obi_req_t         bus_req_o,
  input  obi_resp_t        bus_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              pend_ok;
  logic              rsp_accept;
  logic              dec;
  logic              stray;
  logic              rvalid_c;
  logic [ObiDataW-1:0] rdata_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  obi_buf_entry_t    push_data;
  obi_buf_entry_t    head;

  // Core accept from registered full and count only.
  assign push = core_req_i.req && !fifo_full && (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign pop  = !fifo_empty && bus_resp_i.gnt;

  always_comb begin
    push_data       = '0;
    push_data.addr  = core_req_i.addr;
    push_data.we    = core_req_i.we;
    push_data.be    = core_req_i.be;
    push_data.wdata = core_req_i.wdata;
  end

  obi_req_buffer_fifo #(
    .T     (obi_buf_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign bus_req_o = to_bus_req(!fifo_empty, head);

`ifdef OBI_REQ_BUFFER_RESP_REG_EN
  logic              rvalid_q;
  logic [ObiDataW-1:0] rdata_q;

  // A response already held in the register has not yet been subtracted,
  // so it must not be counted as pending for a new bus rvalid.
  assign pend_ok    = cnt_q > CNT_W'(rvalid_q);
  assign rsp_accept = bus_resp_i.rvalid && pend_ok;
  assign dec        = rvalid_q;
  assign rvalid_c   = rvalid_q;
  assign rdata_c    = rdata_q;

  // Response register toward the core.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rsp_accept;
      if (rsp_accept) rdata_q <= bus_resp_i.rdata;
    end
  end
`else
  assign pend_ok    = (cnt_q != '0);
  assign rsp_accept = bus_resp_i.rvalid && pend_ok;
  assign dec        = rsp_accept;
  assign rvalid_c   = rsp_accept;
  assign rdata_c    = bus_resp_i.rdata;
`endif

  assign stray = bus_resp_i.rvalid && !pend_ok;

  always_comb begin
    core_resp_o        = '0;
    core_resp_o.gnt    = push;
    core_resp_o.rvalid = rvalid_c;
    core_resp_o.rdata  = rdata_c;
  end

  // Outstanding counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case ({push, dec})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (stray) err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_obi_req_buffer.sv
// Directed bench for obi_req_buffer (DEPTH=2, MAX_OUTSTANDING=4).
module tb_obi_req_buffer;
  import obi_pkg::*;

  logic      clk;
  logic      rst;
  obi_req_t  core_req;
  obi_resp_t core_resp;
  obi_req_t  bus_req;
  obi_resp_t bus_resp;
  logic [2:0] outstanding;
  logic      err;

  int tests;
  int fails;

  obi_req_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (core_req),
    .core_resp_o   (core_resp),
    .bus_req_o     (bus_req),
    .bus_resp_i    (bus_resp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic obi_req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.addr  = a;
    r.we    = w;
    r.be    = 4'hF;
    r.wdata = d;
    return r;
  endfunction

  function automatic obi_resp_t rsp(input logic g, input logic v, input logic [31:0] d);
    obi_resp_t r;
    r.gnt    = g;
    r.rvalid = v;
    r.rdata  = d;
    return r;
  endfunction

  // Read of 0x180 returning 0xDEADBEEF; starts and ends at posedge+1.
  task automatic single_read;
    core_req = mk(32'h180, 1'b0, 32'h0);
    #1 chk("rd_gnt", 80'(core_resp.gnt), 80'd1);
    tick;
    core_req = '0;
    #1;
    chk("rd_issue_req", 80'(bus_req.req), 80'd1);
    chk("rd_issue_addr", 80'(bus_req.addr), 80'h180);
    chk("rd_out1", 80'(outstanding), 80'd1);
    bus_resp = rsp(1'b1, 1'b0, 32'h0);
    tick;
    bus_resp = rsp(1'b0, 1'b1, 32'hDEADBEEF);
    #1;
    chk("rd_bus_idle", 80'(bus_req.req), 80'd0);
`ifdef OBI_REQ_BUFFER_RESP_REG_EN
    chk("rd_rvalid_early", 80'(core_resp.rvalid), 80'd0);
    tick;
    bus_resp = '0;
    #1;
    chk("rd_rvalid", 80'(core_resp.rvalid), 80'd1);
    chk("rd_rdata", 80'(core_resp.rdata), 80'hDEADBEEF);
    chk("rd_out_hold", 80'(outstanding), 80'd1);
    tick;
`else
    chk("rd_rvalid", 80'(core_resp.rvalid), 80'd1);
    chk("rd_rdata", 80'(core_resp.rdata), 80'hDEADBEEF);
    chk("rd_out_hold", 80'(outstanding), 80'd1);
    tick;
    bus_resp = '0;
`endif
    chk("rd_out0", 80'(outstanding), 80'd0);
    chk("rd_no_err", 80'(err), 80'd0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    core_req = '0;
    bus_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 80'(bus_req), 80'd0);
    chk("rst_core_resp", 80'(core_resp), 80'd0);
    chk("rst_out", 80'(outstanding), 80'd0);
    chk("rst_err", 80'(err), 80'd0);
    rst = 1'b0;
    tick;

    single_read();

    // Back-to-back writes with bus gnt held low, then released.
    core_req = mk(32'h1000, 1'b1, 32'hC0DE0000);
    #1 chk("w0_gnt", 80'(core_resp.gnt), 80'd1);
    tick;
    core_req = mk(32'h1004, 1'b1, 32'hC0DE0001);
    #1;
    chk("w1_gnt", 80'(core_resp.gnt), 80'd1);
    chk("w_head_a", 80'(bus_req.addr), 80'h1000);
    tick;
    core_req = mk(32'h1008, 1'b1, 32'hC0DE0002);
    #1;
    chk("w2_stall", 80'(core_resp.gnt), 80'd0);
    chk("w_head_stable", 80'(bus_req.addr), 80'h1000);
    chk("w_out2", 80'(outstanding), 80'd2);
    tick;
    bus_resp = rsp(1'b1, 1'b0, 32'h0);
    #1;
    chk("w2_full_blocks", 80'(core_resp.gnt), 80'd0);
    chk("iss0_addr", 80'(bus_req.addr), 80'h1000);
    chk("iss0_wdata", 80'(bus_req.wdata), 80'hC0DE0000);
    tick;
    chk("w2_gnt", 80'(core_resp.gnt), 80'd1);
    chk("iss1_addr", 80'(bus_req.addr), 80'h1004);
    chk("iss1_wdata", 80'(bus_req.wdata), 80'hC0DE0001);
    tick;
    core_req = mk(32'h100C, 1'b1, 32'hC0DE0003);
    #1;
    chk("w3_gnt", 80'(core_resp.gnt), 80'd1);
    chk("iss2_addr", 80'(bus_req.addr), 80'h1008);
    chk("iss2_wdata", 80'(bus_req.wdata), 80'hC0DE0002);
    chk("pp_occ", 80'(bus_req.req), 80'd1);
    chk("pp_out", 80'(outstanding), 80'd3);
    tick;
    // Fifth request meets the outstanding limit.
    core_req = mk(32'h2000, 1'b0, 32'h0);
    #1;
    chk("iss3_addr", 80'(bus_req.addr), 80'h100C);
    chk("iss3_we", 80'(bus_req.we), 80'd1);
    chk("lim_out4", 80'(outstanding), 80'd4);
    chk("lim_block", 80'(core_resp.gnt), 80'd0);
    tick;
    bus_resp = rsp(1'b0, 1'b1, 32'h11110000);
    #1;
    chk("lim_drained", 80'(bus_req.req), 80'd0);
    chk("lim_block_rsp", 80'(core_resp.gnt), 80'd0);
    tick;
    bus_resp = '0;
`ifdef OBI_REQ_BUFFER_RESP_REG_EN
    #1 chk("lim_wait", 80'(core_resp.gnt), 80'd0);
    tick;
`endif
    #1;
    chk("lim_5th_gnt", 80'(core_resp.gnt), 80'd1);
    chk("lim_out3", 80'(outstanding), 80'd3);
    tick;
    core_req = '0;
    for (int i = 0; i < 4; i++) begin
      bus_resp = rsp(1'b1, 1'b1, 32'h22220000 + 32'(i));
      tick;
    end
    bus_resp = '0;
    tick;
    tick;
    chk("drain_out0", 80'(outstanding), 80'd0);
    chk("drain_err", 80'(err), 80'd0);

    // Stray response on an idle buffer.
    bus_resp = rsp(1'b0, 1'b1, 32'h12345678);
    #1;
    chk("stray_fwd", 80'(core_resp.rvalid), 80'd0);
    tick;
    bus_resp = '0;
    #1;
    chk("stray_err", 80'(err), 80'd1);
    chk("stray_out", 80'(outstanding), 80'd0);
    tick;
    tick;
    chk("stray_sticky", 80'(err), 80'd1);

    // Asynchronous reset with two queued entries.
    core_req = mk(32'h3000, 1'b0, 32'h0);
    tick;
    core_req = mk(32'h3004, 1'b0, 32'h0);
    tick;
    core_req = '0;
    #1;
    chk("rmo_req", 80'(bus_req.req), 80'd1);
    chk("rmo_out2", 80'(outstanding), 80'd2);
    #2 rst = 1'b1;
    #1;
    chk("rmo_async_req", 80'(bus_req.req), 80'd0);
    chk("rmo_async_bus", 80'(bus_req), 80'd0);
    chk("rmo_async_out", 80'(outstanding), 80'd0);
    chk("rmo_err_clr", 80'(err), 80'd0);
    #1 rst = 1'b0;
    tick;
    single_read();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
